// File: rtl/throughout_window_checker.sv
// throughout_window_checker
// Multi-channel protocol monitor. On each channel the qualifier en must stay
// high, and the conflict req_a & req_b must stay low, for WIN_LEN consecutive
// sampled cycles. Every finished attempt is reported as a one-cycle pass or
// fail pulse. A fail carries its cause as {conflict, qual}, and a qualifier
// drop wins over a conflict. Aggregate saturating counters and sticky
// per-channel fail flags can be read by software.
module throughout_window_checker #(
    parameter int NUM_CH      = 4,
    parameter int WIN_LEN     = 4,
    parameter int CNT_W       = 16,
    parameter int STRICT_IDLE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [NUM_CH-1:0]   en,
    input  logic [NUM_CH-1:0]   req_a,
    input  logic [NUM_CH-1:0]   req_b,
    output logic [NUM_CH-1:0]   busy,
    output logic [NUM_CH-1:0]   pass_pulse,
    output logic [NUM_CH-1:0]   fail_pulse,
    output logic [2*NUM_CH-1:0] fail_cause,
    output logic [NUM_CH-1:0]   fail_seen,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt
);

    localparam int WC_W  = $clog2(WIN_LEN + 1);
    localparam int POP_W = $clog2(NUM_CH + 1);
    localparam int ADD_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

    // The window is complete when the count already reached reaches WIN_LEN-1.
    localparam logic [WC_W-1:0]  WC_LAST = WC_W'(WIN_LEN - 1);
    localparam logic [ADD_W-1:0] CNT_MAX = ADD_W'({CNT_W{1'b1}});

    localparam logic [1:0] CAUSE_QUAL = 2'b01;
    localparam logic [1:0] CAUSE_CONF = 2'b10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              r_state [NUM_CH];
    logic [WC_W-1:0]     r_wc    [NUM_CH];
    logic [NUM_CH-1:0]   r_busy;
    logic [NUM_CH-1:0]   r_pass;
    logic [NUM_CH-1:0]   r_fail;
    logic [2*NUM_CH-1:0] r_cause;
    logic [NUM_CH-1:0]   r_fail_seen;
    logic [CNT_W-1:0]    r_pass_cnt;
    logic [CNT_W-1:0]    r_fail_cnt;

    state_t              w_state_nxt [NUM_CH];
    logic [WC_W-1:0]     w_wc_nxt    [NUM_CH];
    logic [NUM_CH-1:0]   w_conflict;
    logic [NUM_CH-1:0]   w_busy_nxt;
    logic [NUM_CH-1:0]   w_pass_nxt;
    logic [NUM_CH-1:0]   w_fail_nxt;
    logic [2*NUM_CH-1:0] w_cause_nxt;
    logic [CNT_W-1:0]    w_pass_cnt_nxt;
    logic [CNT_W-1:0]    w_fail_cnt_nxt;

    // Number of channels reporting in a cycle.
    function automatic logic [POP_W-1:0] popcount(input logic [NUM_CH-1:0] v);
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

    // Add with clamp at the all-ones value of the counter. The counter never wraps.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                 input logic [POP_W-1:0] inc);
        logic [ADD_W-1:0] sum;
        sum = ADD_W'(cnt) + ADD_W'(inc);
        if (sum > CNT_MAX) begin
            sum = CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    assign w_conflict = req_a & req_b;

    // Per-channel window decision: next state, window count and this edge's report.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
            w_state_nxt[i]     = S_IDLE;
            w_wc_nxt[i]        = '0;
            w_pass_nxt[i]      = 1'b0;
            w_fail_nxt[i]      = 1'b0;
            w_cause_nxt[2*i+:2] = 2'b00;

            case (r_state[i])
                S_IDLE: begin
                    if (!en[i]) begin
                        if (STRICT_IDLE != 0) begin
                            w_fail_nxt[i]       = 1'b1;
                            w_cause_nxt[2*i+:2] = CAUSE_QUAL;
                        end
                    end else if (w_conflict[i]) begin
                        w_fail_nxt[i]       = 1'b1;
                        w_cause_nxt[2*i+:2] = CAUSE_CONF;
                    end else if (WIN_LEN == 1) begin
                        w_pass_nxt[i] = 1'b1;
                    end else begin
                        w_state_nxt[i] = S_RUN;
                        w_wc_nxt[i]    = WC_W'(1);
                    end
                end
                S_RUN: begin
                    if (!en[i]) begin
                        w_fail_nxt[i]       = 1'b1;
                        w_cause_nxt[2*i+:2] = CAUSE_QUAL;
                    end else if (w_conflict[i]) begin
                        w_fail_nxt[i]       = 1'b1;
                        w_cause_nxt[2*i+:2] = CAUSE_CONF;
                    end else if (r_wc[i] == WC_LAST) begin
                        w_pass_nxt[i] = 1'b1;
                    end else begin
                        w_state_nxt[i] = S_RUN;
                        w_wc_nxt[i]    = r_wc[i] + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt[i] = S_IDLE;
                end
            endcase

            w_busy_nxt[i] = (w_state_nxt[i] == S_RUN);
        end
    end

    assign w_pass_cnt_nxt = sat_add(r_pass_cnt, popcount(w_pass_nxt));
    assign w_fail_cnt_nxt = sat_add(r_fail_cnt, popcount(w_fail_nxt));

    // Register the channel FSMs, the report outputs and the aggregate status.
    // clr aborts every window and zeroes the status, ignoring that edge's inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the per-channel arrays hold FSM control state, so each element is reset, unlike a data RAM.
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_wc[i]    <= '0;
            end
            r_busy      <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_cause     <= '0;
            r_fail_seen <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else if (clr) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= S_IDLE;
                r_wc[i]    <= '0;
            end
            r_busy      <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_cause     <= '0;
            r_fail_seen <= '0;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the pre-edge values.
            for (int i = 0; i < NUM_CH; i++) begin
                r_state[i] <= w_state_nxt[i];
                r_wc[i]    <= w_wc_nxt[i];
            end
            r_busy      <= w_busy_nxt;
            r_pass      <= w_pass_nxt;
            r_fail      <= w_fail_nxt;
            r_cause     <= w_cause_nxt;
            r_fail_seen <= r_fail_seen | w_fail_nxt;
            r_pass_cnt  <= w_pass_cnt_nxt;
            r_fail_cnt  <= w_fail_cnt_nxt;
        end
    end

    assign busy       = r_busy;
    assign pass_pulse = r_pass;
    assign fail_pulse = r_fail;
    assign fail_cause = r_cause;
    assign fail_seen  = r_fail_seen;
    assign pass_cnt   = r_pass_cnt;
    assign fail_cnt   = r_fail_cnt;

endmodule

// File: tb/tb_throughout_window_checker.sv
// Testbench for throughout_window_checker.
// The main instance uses the default parameters. A STRICT_IDLE=1 instance and
// a CNT_W=3 instance cover idle reporting and counter saturation. Pulses from
// the main instance go through a scoreboard. Stimulus pushes the
// hand-computed events, and a monitor pops and compares them when pulses appear.
module tb_throughout_window_checker;

    logic clk;
    logic rst_n;

    // Main instance: NUM_CH=4, WIN_LEN=4, CNT_W=16, STRICT_IDLE=0.
    logic       clr;
    logic [3:0] en, req_a, req_b;
    logic [3:0] busy, pass_pulse, fail_pulse, fail_seen;
    logic [7:0] fail_cause;
    logic [15:0] pass_cnt, fail_cnt;

    // Strict-idle instance.
    logic       s_clr;
    logic [3:0] s_en, s_req_a, s_req_b;
    logic [3:0] s_busy, s_pass, s_fail, s_seen;
    logic [7:0] s_cause;
    logic [15:0] s_pcnt, s_fcnt;

    // Narrow-counter instance.
    logic       c_clr;
    logic [3:0] c_en, c_req_a, c_req_b;
    logic [3:0] c_busy, c_pass, c_fail, c_seen;
    logic [7:0] c_cause;
    logic [2:0] c_pcnt, c_fcnt;

    throughout_window_checker u_dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .en(en), .req_a(req_a), .req_b(req_b),
        .busy(busy), .pass_pulse(pass_pulse), .fail_pulse(fail_pulse),
        .fail_cause(fail_cause), .fail_seen(fail_seen),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    throughout_window_checker #(.STRICT_IDLE(1)) u_strict (
        .clk(clk), .rst_n(rst_n), .clr(s_clr),
        .en(s_en), .req_a(s_req_a), .req_b(s_req_b),
        .busy(s_busy), .pass_pulse(s_pass), .fail_pulse(s_fail),
        .fail_cause(s_cause), .fail_seen(s_seen),
        .pass_cnt(s_pcnt), .fail_cnt(s_fcnt)
    );

    throughout_window_checker #(.CNT_W(3)) u_small (
        .clk(clk), .rst_n(rst_n), .clr(c_clr),
        .en(c_en), .req_a(c_req_a), .req_b(c_req_b),
        .busy(c_busy), .pass_pulse(c_pass), .fail_pulse(c_fail),
        .fail_cause(c_cause), .fail_seen(c_seen),
        .pass_cnt(c_pcnt), .fail_cnt(c_fcnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count of posedges so far. An event tagged k belongs to posedge k.
    int edge_n = 0;
    always @(posedge clk) edge_n <= edge_n + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int         at_edge;
        int         ch;
        bit         is_pass;
        logic [1:0] cause;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [3:0] en, a, b;
        logic [3:0] pass, fail;
        logic [7:0] cause;
        logic [3:0] busy;
        int         pcnt, fcnt;
        logic [3:0] seen;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] en_v, a_v, b_v, p_v, f_v,
                                input logic [7:0] c_v, input logic [3:0] bz,
                                input int pc, fc, input logic [3:0] sn);
        vec_t v;
        v.en = en_v; v.a = a_v; v.b = b_v; v.pass = p_v; v.fail = f_v;
        v.cause = c_v; v.busy = bz; v.pcnt = pc; v.fcnt = fc; v.seen = sn;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Push the expected events for the coming edge, drive the main instance, then check its status.
    task automatic apply(input string tag, input vec_t v);
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin
            if (v.pass[ch] || v.fail[ch]) begin
                e.at_edge = edge_n + 1;
                e.ch      = ch;
                e.is_pass = v.pass[ch];
                e.cause   = v.cause[2*ch+:2];
                sb_q.push_back(e);
            end
        end
        en = v.en; req_a = v.a; req_b = v.b;
        tick();
        check({tag, "_busy"},  busy,       v.busy);
        check({tag, "_cause"}, fail_cause, v.cause);
        check({tag, "_pcnt"},  pass_cnt,   v.pcnt);
        check({tag, "_fcnt"},  fail_cnt,   v.fcnt);
        check({tag, "_seen"},  fail_seen,  v.seen);
    endtask

    // Scoreboard monitor: pops an expected event whenever a channel pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                while (sb_q.size() > 0 && sb_q[0].at_edge < edge_n) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_missing: edge %0d ch %0d pulse absent, required pass=%0b",
                             sb_q[0].at_edge, sb_q[0].ch, sb_q[0].is_pass);
                    void'(sb_q.pop_front());
                end
                for (int ch = 0; ch < 4; ch++) begin
                    if (pass_pulse[ch] || fail_pulse[ch]) begin
                        if (sb_q.size() == 0 || sb_q[0].at_edge != edge_n || sb_q[0].ch != ch) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL sb_unexpected: edge %0d ch %0d got pass=%0b fail=%0b, required no pulse",
                                     edge_n, ch, pass_pulse[ch], fail_pulse[ch]);
                        end else begin
                            e = sb_q.pop_front();
                            check($sformatf("sb_pass_e%0d_ch%0d", edge_n, ch), 32'(pass_pulse[ch]), 32'(e.is_pass));
                            check($sformatf("sb_fail_e%0d_ch%0d", edge_n, ch), 32'(fail_pulse[ch]), 32'(!e.is_pass));
                            check($sformatf("sb_cause_e%0d_ch%0d", edge_n, ch), 32'(fail_cause[2*ch+:2]), 32'(e.cause));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl [22];

    initial begin
        //            en       a        b        pass     fail     cause         busy   pc fc seen
        tbl[0]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0001, 0, 0, 4'b0000);
        tbl[1]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0001, 0, 0, 4'b0000);
        tbl[2]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0001, 0, 0, 4'b0000);
        tbl[3]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'b0000_0000, 4'b0000, 1, 0, 4'b0000);
        tbl[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0000, 1, 0, 4'b0000);
        tbl[5]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0010, 1, 0, 4'b0000);
        tbl[6]  = mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0010, 1, 0, 4'b0000);
        tbl[7]  = mk(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 8'b0000_0100, 4'b0000, 1, 1, 4'b0010);
        tbl[8]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0100, 1, 1, 4'b0010);
        tbl[9]  = mk(4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 8'b0010_0000, 4'b0000, 1, 2, 4'b0110);
        tbl[10] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0100, 1, 2, 4'b0110);
        tbl[11] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0100, 1, 2, 4'b0110);
        tbl[12] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0100, 1, 2, 4'b0110);
        tbl[13] = mk(4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 8'b0000_0000, 4'b0000, 2, 2, 4'b0110);
        tbl[14] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0000, 2, 2, 4'b0110);
        tbl[15] = mk(4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'b1000_0000, 4'b0000, 2, 3, 4'b1110);
        tbl[16] = mk(4'b1111, 4'b0011, 4'b0001, 4'b0000, 4'b0001, 8'b0000_0010, 4'b1110, 2, 4, 4'b1111);
        tbl[17] = mk(4'b1110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b1110, 2, 4, 4'b1111);
        tbl[18] = mk(4'b1100, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 8'b0000_0100, 4'b1100, 2, 5, 4'b1111);
        tbl[19] = mk(4'b1100, 4'b1100, 4'b1100, 4'b0000, 4'b1100, 8'b1010_0000, 4'b0000, 2, 7, 4'b1111);
        tbl[20] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'b0000_0000, 4'b0001, 2, 7, 4'b1111);
        tbl[21] = mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 8'b0000_0001, 4'b0000, 2, 8, 4'b1111);
    end

    initial begin
        clr = 1'b0;  en = '0;   req_a = '0;   req_b = '0;
        s_clr = 1'b1; s_en = '0; s_req_a = '0; s_req_b = '0;
        c_clr = 1'b1; c_en = '0; c_req_a = '0; c_req_b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_busy",  busy,       4'h0);
        check("rst_pass",  pass_pulse, 4'h0);
        check("rst_fail",  fail_pulse, 4'h0);
        check("rst_cause", fail_cause, 8'h00);
        check("rst_seen",  fail_seen,  4'h0);
        check("rst_pcnt",  pass_cnt,   16'd0);
        check("rst_fcnt",  fail_cnt,   16'd0);
        #1 rst_n = 1'b1;

        // Windows, conflicts, qualifier drops and priorities on the main instance.
        for (int i = 0; i < 22; i++) begin
            apply($sformatf("row%0d", i), tbl[i]);
        end

        // A clear in the middle of a window aborts it with no report and zeroes the status.
        apply("clr_start", mk(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0010, 2, 8, 4'b1111));
        clr = 1'b1;
        apply("clr_edge",  mk(4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000));
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("idle_quiet%0d", i), mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 0, 0, 4'b0000));
        end

        // Strict idle: every idle channel fails with cause qual on every edge.
        check("strict_pre_fcnt", s_fcnt, 16'd0);
        s_clr = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check($sformatf("strict%0d_fail", i),  s_fail,  4'hF);
            check($sformatf("strict%0d_cause", i), s_cause, 8'h55);
            check($sformatf("strict%0d_pass", i),  s_pass,  4'h0);
            check($sformatf("strict%0d_fcnt", i),  s_fcnt,  32'(4 * i));
        end
        s_clr = 1'b1;
        tick();
        check("strict_clr_fcnt", s_fcnt, 16'd0);

        // Narrow counter: nine back-to-back passes on ch0 saturate at 7.
        c_clr = 1'b0;
        c_en  = 4'b0001;
        for (int j = 1; j <= 36; j++) begin
            tick();
            if (j % 4 == 0) begin
                check($sformatf("sat_pass%0d", j), c_pass, 4'b0001);
                check($sformatf("sat_pcnt%0d", j), c_pcnt, 32'((j / 4 < 7) ? j / 4 : 7));
            end
        end
        c_en  = 4'b0000;
        c_clr = 1'b1;

        // Asynchronous reset mid-window: outputs clear at once, and no pass or fail is reported.
        apply("pre_rst0", mk(4'b1001, 4'b1000, 4'b1000, 4'b0000, 4'b1000, 8'b1000_0000, 4'b0001, 0, 1, 4'b1000));
        apply("pre_rst1", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00,        4'b0001, 0, 1, 4'b1000));
        #3 rst_n = 1'b0;
        en = '0;
        #1;
        check("arst_busy",  busy,       4'h0);
        check("arst_pass",  pass_pulse, 4'h0);
        check("arst_fail",  fail_pulse, 4'h0);
        check("arst_cause", fail_cause, 8'h00);
        check("arst_seen",  fail_seen,  4'h0);
        check("arst_fcnt",  fail_cnt,   16'd0);
        check("arst_pcnt",  pass_cnt,   16'd0);
        #2 rst_n = 1'b1;
        apply("post_rst0", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001, 0, 0, 4'b0000));
        apply("post_rst1", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001, 0, 0, 4'b0000));
        apply("post_rst2", mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0001, 0, 0, 4'b0000));
        apply("post_rst3", mk(4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 8'h00, 4'b0000, 1, 0, 4'b0000));
        apply("post_idle", mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 8'h00, 4'b0000, 1, 0, 4'b0000));

        @(negedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/throughout_window_checker.md
Name: throughout_window_checker

Overview:
- Synthesizable, parametrised multi-channel successor to the "qualifier throughout no-conflict" property check.
- Per channel: qualifier en must stay high, and conflict (req_a && req_b) must stay low, for WIN_LEN consecutive sampled cycles.
- Reports pass/fail per window with a fail cause (qualifier dropped vs conflict) and keeps aggregate saturating counters.
- Sits beside the datapath as an on-chip protocol monitor; status is readable by software/bench.

Parameters:
NUM_CH, 4, number of independent channels
WIN_LEN, 4, cycles (>=1) the condition must hold for a pass
CNT_W, 16, width of pass_cnt/fail_cnt
STRICT_IDLE, 0, 1 = every idle cycle with en=0 reports a QUAL fail; 0 = idle en=0 is silent

Ports:
clk  input  1  clock, all sampling on posedge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear: abort all windows, zero counters and sticky flags
en  input  NUM_CH  per-channel qualifier
req_a  input  NUM_CH  per-channel conflict source A
req_b  input  NUM_CH  per-channel conflict source B
busy  output  NUM_CH  channel has a window in progress
pass_pulse  output  NUM_CH  one-cycle pass indication
fail_pulse  output  NUM_CH  one-cycle fail indication
fail_cause  output  2*NUM_CH  per channel {conflict,qual}, valid with fail_pulse, else 0
fail_seen  output  NUM_CH  sticky per-channel fail flag
pass_cnt  output  CNT_W  total passes, saturating
fail_cnt  output  CNT_W  total fails, saturating

Behaviour:
- Reset (rst_n=0, async): all channels IDLE, window counters 0. busy, pass_pulse, fail_pulse, fail_cause, fail_seen, pass_cnt, fail_cnt all 0.
- Per-channel conflict c = req_a & req_b. Evaluate each posedge with sampled inputs. All outputs are registered: the result of edge k is visible from edge k until edge k+1.
- FSM states per channel: IDLE, RUN. Window count wc ranges 1..WIN_LEN.
- IDLE:
  - en=0: stay IDLE. If STRICT_IDLE=1, fail_pulse=1 with cause qual=1.
  - en=1 and c=1: fail_pulse, cause conflict=1; stay IDLE.
  - en=1 and c=0: if WIN_LEN=1, pass_pulse and stay IDLE; else go to RUN with wc=1 and busy=1.
- RUN:
  - en=0: fail, cause qual=1 (qual has priority over conflict; only one cause bit is set). Go to IDLE.
  - else c=1: fail, cause conflict=1. Go to IDLE.
  - else wc+1 = WIN_LEN: pass_pulse, go to IDLE.
  - else wc++.
- Attempts are non-overlapping. The edge after a pass or fail is evaluated as a fresh IDLE start. A window starting at edge k passes at edge k+WIN_LEN-1.
- busy = (state==RUN) after the edge.
- pass_pulse and fail_pulse are never both set on one channel in the same cycle.
- fail_seen[i] is set on any fail of channel i and held until clr.
- Counters: each cycle add popcount(pass_pulse-next) to pass_cnt and popcount(fail_pulse-next) to fail_cnt. Saturate at 2^CNT_W-1; no wrap.
- clr=1 (sync, highest priority after reset): all channels to IDLE; no pulses; counters and fail_seen zeroed that edge; inputs that edge are ignored.
- rst_n asserted mid-window: abort immediately, with no pass or fail reported.
- Inputs are treated as synchronous to clk. X on inputs is not handled.

Test Plan:
1. NUM_CH=4, WIN_LEN=4, ch0: en=1, req_a=req_b=0 for 4 edges (k..k+3) -> pass_pulse[0] after edge k+3 only; busy[0]=1 after k..k+2; pass_cnt=1.
2. ch1: en=1 for 2 edges, then en=0 with req_a=req_b=1 -> fail_pulse[1] at 3rd edge, fail_cause[3:2]=2'b01 (qual), fail_seen[1]=1, fail_cnt=1.
3. ch2: en=1 throughout, req_a=req_b=1 on 2nd edge -> fail at 2nd edge, cause 2'b10; next edge with clean inputs starts a new window, passing 4 edges later.
4. STRICT_IDLE=1, all en=0 for 5 edges -> fail_pulse=4'hF each edge, fail_cnt increments by 4 per edge (20); STRICT_IDLE=0 -> no pulses, fail_cnt=0.
5. CNT_W=3, force 9 passes on ch0 -> pass_cnt stops at 7. clr mid-window on ch1 -> busy[1]=0 next cycle, no pulse, counters and fail_seen=0.
6. Assert rst_n=0 asynchronously mid-window (between edges) -> all outputs 0 immediately. Release, then clean inputs -> first pass exactly WIN_LEN edges after the first sampled en=1.
